mmu_reg_access_ctrl: RTL and testbench
======================================

// Module: mmu_reg_access_ctrl
// PURPOSE
//  Sequences all accesses to the per-thread MMU special registers: control, context, context-table
//  pointer, fault status (FSR) and fault address (FAR). Shares their single write ports between
//  IU ASI loads/stores and the table-walk fault logger.
//  Schedules the registered (1-cycle) RAM reads and returns read data with parity error.
//  Implements SRMMU read-to-clear of the FSR. Sits between the IU memory stage and the register RAMs.
// PARAMETERS
//  NTHREAD      libconf  thread count; thread ids are NTHREADIDMSB+1 bits
//  LUTRAMPROT   libconf  1: honour reg_luterr on reads; 0: ignore it
//  FSR_RDCLR    1        1: an ASI read of the FSR clears that thread's FSR
// PORTS
//  gclk         in   iu_clk_type  only gclk.clk is used
//  rst          in   1     synchronous, active-high reset
//  req_valid    in   1     ASI request valid
//  req_ready    out  1     request accepted this cycle when req_valid & req_ready
//  req_we       in   1     1 = write (sta), 0 = read (lda)
//  req_sel      in   3     0 ctrl, 1 ctxptr, 2 ctx, 3 FSR, 4 FAR; 5-7 illegal
//  req_tid      in   NTHREADIDMSB+1  thread id of the request
//  req_wdata    in   32    write data
//  flt_valid    in   1     fault record from walker; always accepted, never stalled
//  flt_tid      in   NTHREADIDMSB+1  thread id of the fault
//  flt_fsr      in   32    FSR value to store
//  flt_far      in   32    FAR value to store
//  rsp_valid    out  1     read response valid; held until rsp_ready
//  rsp_ready    in   1     consumer accepts the response
//  rsp_data     out  32    read data
//  rsp_err      out  1     parity error or illegal select
//  reg_rtid     out  NTHREADIDMSB+1  read tid, shared by all five RAMs
//  reg_wtid     out  NTHREADIDMSB+1  write tid, shared by all five RAMs
//  reg_we       out  5     per-register write enable, indexed by sel
//  reg_wdata    out  5x32  per-register write data, packed and indexed by sel
//  reg_rdata    in   5x32  registered RAM outputs
//  reg_luterr   in   5     per-register parity error
// BEHAVIOUR
//  Reset: state IDLE; req_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, reg_we=0, no clear pending.
//   RAM contents are not reset; software initialises them. rst mid-operation aborts any read in flight.
//  FSM IDLE -> RD_WAIT -> RSP -> IDLE.
//   IDLE: req_ready=1 unless blocked (see conflicts).
//   Read accepted in cycle N: reg_rtid=req_tid combinationally in N; latch sel/tid; go to RD_WAIT.
//   RD_WAIT (N+1): capture reg_rdata[sel] and (LUTRAMPROT & reg_luterr[sel]) into rsp regs; go to RSP.
//   RSP (N+2 onward): rsp_valid=1; leave when rsp_ready. Read latency = 2 cycles. One read outstanding.
//   Back-to-back: a new request can be accepted in the cycle after the RSP handshake.
//  Write accepted in IDLE: reg_we[sel]=1, reg_wtid=req_tid, reg_wdata[sel]=req_wdata in the same
//   cycle. No response; state stays IDLE. Writes are not accepted in RD_WAIT or RSP.
//  Illegal sel: a read skips RAM access and returns rsp_data=0, rsp_err=1 at the same latency;
//   a write is dropped silently.
//  Fault: flt_valid writes FSR and FAR (reg_we[3], reg_we[4]) for flt_tid in the same cycle.
//  Conflicts:
//   - flt_valid & an ASI write with sel 3/4 -> req_ready=0 for that cycle; the fault write wins.
//   - An ASI write to sel 0-2 proceeds in parallel with a fault.
//   - reg_wtid is shared, so a parallel write requires req_tid==flt_tid; otherwise req_ready=0.
//  Read-to-clear (FSR_RDCLR=1, sel 3): in RD_WAIT, write 0 to FSR[tid].
//   Suppress the clear if flt_valid for the same tid in cycle N or N+1; the fault is newer than the
//   value read. A flt_valid for a different tid in RD_WAIT delays the clear to RSP's first cycle.
//  FAR is never cleared by a read.
// STRUCTURE
//  libmmu additions: mmu_reg_sel_type enum (MMUREG_CTRL..MMUREG_FAR), constant MMUREG_NUM=5,
//   typedef mmu_reg_req_type {we, sel, tid, wdata}.
//  Single module. The 5:1 read mux plus luterr select is a small always_comb; no sub-module.
//  Instantiates no RAMs; the five register RAMs are wired to it at the MMU top level.
// TESTING
//  1. Write ctx tid 2 = 0x0000_00A5, then read ctx tid 2 -> rsp_valid 2 cycles after accept,
//     rsp_data=0x0000_00A5, rsp_err=0.
//  2. Fault tid 1 fsr=0x0000_0824 far=0x4000_1000; read FSR tid 1 -> 0x0000_0824.
//     A second FSR read of tid 1 -> 0.
//  3. Read FSR tid 1 with flt_valid tid 1 in cycle N+1 -> response is the old value;
//     the FSR afterwards holds the new fault (clear suppressed).
//  4. ASI write FAR tid 0 together with flt_valid tid 3 -> req_ready=0 that cycle;
//     the write lands next cycle; FAR[3] = fault value.
//  5. Force reg_luterr[0] during a ctrl read -> rsp_err=1. Read sel=6 -> rsp_data=0, rsp_err=1,
//     and no reg_we pulse.
//  6. Hold rsp_ready=0 for 4 cycles -> rsp_valid/rsp_data stable, req_ready=0.
//     Assert rst in RSP -> rsp_valid=0 next cycle, state IDLE.

Source files
------------

// File: rtl/mmu_reg_access_ctrl_pkg.sv
// Shared types for the MMU special-register access controller: register select
// encoding, request record and controller states.
package mmu_reg_access_ctrl_pkg;

  localparam int NTHREAD    = 4;
  localparam int TID_W      = (NTHREAD > 1) ? $clog2(NTHREAD) : 1;
  localparam int MMUREG_NUM = 5;

  typedef enum logic [2:0] {
    MMUREG_CTRL   = 3'd0,
    MMUREG_CTXPTR = 3'd1,
    MMUREG_CTX    = 3'd2,
    MMUREG_FSR    = 3'd3,
    MMUREG_FAR    = 3'd4
  } mmu_reg_sel_e;

  typedef struct packed {
    logic             we;
    logic [2:0]       sel;
    logic [TID_W-1:0] tid;
    logic [31:0]      wdata;
  } mmu_reg_req_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RSP     = 2'd2
  } state_e;

  function automatic logic sel_legal(input logic [2:0] sel);
    return sel < 3'(MMUREG_NUM);
  endfunction

endpackage

// File: rtl/mmu_reg_access_ctrl.sv
// Arbitrates IU ASI accesses and walker fault logging onto the per-thread MMU
// special-register RAMs; sequences registered reads and FSR read-to-clear.
//
// state      | meaning
// ST_IDLE    | accepting requests; writes complete here
// ST_RD_WAIT | RAM read in flight; capture data, issue FSR clear
// ST_RSP     | response held until rsp_ready_i
module mmu_reg_access_ctrl
  import mmu_reg_access_ctrl_pkg::*;
#(
  parameter bit LUTRAMPROT = 1'b1,
  parameter bit FSR_RDCLR  = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_we_i,
  input  logic [2:0]                   req_sel_i,
  input  logic [TID_W-1:0]             req_tid_i,
  input  logic [31:0]                  req_wdata_i,
  input  logic                         flt_valid_i,
  input  logic [TID_W-1:0]             flt_tid_i,
  input  logic [31:0]                  flt_fsr_i,
  input  logic [31:0]                  flt_far_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [31:0]                  rsp_data_o,
  output logic                         rsp_err_o,
  output logic [TID_W-1:0]             reg_rtid_o,
  output logic [TID_W-1:0]             reg_wtid_o,
  output logic [MMUREG_NUM-1:0]        reg_we_o,
  output logic [MMUREG_NUM-1:0][31:0]  reg_wdata_o,
  input  logic [MMUREG_NUM-1:0][31:0]  reg_rdata_i,
  input  logic [MMUREG_NUM-1:0]        reg_luterr_i
);

  state_e           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [TID_W-1:0] tid_q, tid_d;
  logic             sup_q, sup_d;
  logic             clr_pend_q, clr_pend_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  mmu_reg_req_t     req;
  logic             wr_conflict;
  logic             accept;

  assign req = '{we: req_we_i, sel: req_sel_i, tid: req_tid_i, wdata: req_wdata_i};

  assign rsp_valid_o = (state_q == ST_RSP);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    tid_d       = tid_q;
    sup_d       = sup_q;
    clr_pend_d  = clr_pend_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    req_ready_o = 1'b0;
    accept      = 1'b0;
    reg_rtid_o  = tid_q;
    reg_wtid_o  = flt_tid_i;
    reg_we_o    = '0;
    reg_wdata_o = '0;

    // The write tid is shared, so a parallel ASI write must target the fault's thread.
    wr_conflict = req.we && flt_valid_i && sel_legal(req.sel) &&
                  ((req.sel >= MMUREG_FSR) || (req.tid != flt_tid_i));

    if (flt_valid_i) begin
      reg_we_o[MMUREG_FSR]    = 1'b1;
      reg_we_o[MMUREG_FAR]    = 1'b1;
      reg_wdata_o[MMUREG_FSR] = flt_fsr_i;
      reg_wdata_o[MMUREG_FAR] = flt_far_i;
    end

    // A deferred clear waits for a fault-free cycle; a same-thread fault supersedes it.
    if (clr_pend_q) begin
      if (!flt_valid_i) begin
        reg_we_o[MMUREG_FSR]    = 1'b1;
        reg_wdata_o[MMUREG_FSR] = '0;
        reg_wtid_o              = tid_q;
        clr_pend_d              = 1'b0;
      end else if (flt_tid_i == tid_q) begin
        clr_pend_d = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        reg_rtid_o  = req.tid;
        req_ready_o = !rst_i && !clr_pend_q && !wr_conflict;
        accept      = req_valid_i && req_ready_o;
        if (accept) begin
          if (req.we) begin
            if (sel_legal(req.sel)) begin
              reg_we_o[req.sel]    = 1'b1;
              reg_wdata_o[req.sel] = req.wdata;
              reg_wtid_o           = req.tid;
            end
          end else begin
            sel_d   = req.sel;
            tid_d   = req.tid;
            sup_d   = flt_valid_i && (flt_tid_i == req.tid);
            state_d = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        if (sel_legal(sel_q)) begin
          rsp_data_d = reg_rdata_i[sel_q];
          rsp_err_d  = LUTRAMPROT && reg_luterr_i[sel_q];
        end else begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end
        if (FSR_RDCLR && (sel_q == MMUREG_FSR) && !sup_q &&
            !(flt_valid_i && (flt_tid_i == tid_q))) begin
          if (flt_valid_i) begin
            clr_pend_d = 1'b1;
          end else begin
            reg_we_o[MMUREG_FSR]    = 1'b1;
            reg_wdata_o[MMUREG_FSR] = '0;
            reg_wtid_o              = tid_q;
          end
        end
        state_d = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      tid_q      <= '0;
      sup_q      <= 1'b0;
      clr_pend_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      tid_q      <= tid_d;
      sup_q      <= sup_d;
      clr_pend_q <= clr_pend_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_mmu_reg_access_ctrl.sv
// Directed bench for mmu_reg_access_ctrl with a behavioural model of the five
// registered per-thread register RAMs.
module tb_mmu_reg_access_ctrl;
  import mmu_reg_access_ctrl_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         req_valid = 1'b0;
  logic                         req_ready;
  logic                         req_we = 1'b0;
  logic [2:0]                   req_sel = '0;
  logic [TID_W-1:0]             req_tid = '0;
  logic [31:0]                  req_wdata = '0;
  logic                         flt_valid = 1'b0;
  logic [TID_W-1:0]             flt_tid = '0;
  logic [31:0]                  flt_fsr = '0;
  logic [31:0]                  flt_far = '0;
  logic                         rsp_valid;
  logic                         rsp_ready = 1'b0;
  logic [31:0]                  rsp_data;
  logic                         rsp_err;
  logic [TID_W-1:0]             reg_rtid;
  logic [TID_W-1:0]             reg_wtid;
  logic [MMUREG_NUM-1:0]        reg_we;
  logic [MMUREG_NUM-1:0][31:0]  reg_wdata;
  logic [MMUREG_NUM-1:0][31:0]  reg_rdata = '0;
  logic [MMUREG_NUM-1:0]        reg_luterr = '0;

  logic [31:0] mem [MMUREG_NUM][NTHREAD];
  int          we_cnt = 0;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mmu_reg_access_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_sel_i    (req_sel),
    .req_tid_i    (req_tid),
    .req_wdata_i  (req_wdata),
    .flt_valid_i  (flt_valid),
    .flt_tid_i    (flt_tid),
    .flt_fsr_i    (flt_fsr),
    .flt_far_i    (flt_far),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .rsp_err_o    (rsp_err),
    .reg_rtid_o   (reg_rtid),
    .reg_wtid_o   (reg_wtid),
    .reg_we_o     (reg_we),
    .reg_wdata_o  (reg_wdata),
    .reg_rdata_i  (reg_rdata),
    .reg_luterr_i (reg_luterr)
  );

  // Registered-read RAM model: read returns the value before a same-cycle write.
  always @(posedge clk) begin
    for (int r = 0; r < MMUREG_NUM; r++) begin
      reg_rdata[r] <= mem[r][reg_rtid];
      if (reg_we[r]) mem[r][reg_wtid] <= reg_wdata[r];
    end
    if (|reg_we) we_cnt <= we_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic we, input logic [2:0] sel, input logic [TID_W-1:0] tid,
                      input logic [31:0] data, input string tag);
    logic acc = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_sel = sel; req_tid = tid; req_wdata = data;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready) begin acc = 1'b1; break; end
      @(negedge clk);
    end
    check({tag, " accept"}, 32'(acc), 32'd1);
    if (acc) @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic fault(input logic [TID_W-1:0] tid, input logic [31:0] fsr, input logic [31:0] far);
    @(negedge clk);
    flt_valid = 1'b1; flt_tid = tid; flt_fsr = fsr; flt_far = far;
    #1;
    check("fault we", 32'(reg_we), 32'b11000);
    @(posedge clk);
    #1;
    flt_valid = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] sel, input logic [TID_W-1:0] tid,
                         input logic [31:0] exp_data, input logic exp_err, input string tag,
                         input logic inj, input logic [TID_W-1:0] itid,
                         input logic [31:0] ifsr, input logic [31:0] ifar);
    send(1'b0, sel, tid, 32'h0, tag);
    @(negedge clk);
    check({tag, " lat1"}, 32'(rsp_valid), 32'd0);
    if (inj) begin
      flt_valid = 1'b1; flt_tid = itid; flt_fsr = ifsr; flt_far = ifar;
      @(posedge clk);
      #1;
      flt_valid = 1'b0;
    end
    @(negedge clk);
    check({tag, " valid"}, 32'(rsp_valid), 32'd1);
    check({tag, " data"}, rsp_data, exp_data);
    check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int cnt0;
    for (int r = 0; r < MMUREG_NUM; r++)
      for (int t = 0; t < NTHREAD; t++) mem[r][t] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_err", 32'(rsp_err), 32'd0);
    check("rst rsp_data", rsp_data, 32'h0);
    check("rst reg_we", 32'(reg_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: ctx write/read
    send(1'b1, 3'd2, 2'd2, 32'h0000_00A5, "wr ctx");
    do_read(3'd2, 2'd2, 32'h0000_00A5, 1'b0, "rd ctx", 1'b0, 2'd0, 32'h0, 32'h0);

    // 2: fault log, read-to-clear of FSR, FAR sticky
    fault(2'd1, 32'h0000_0824, 32'h4000_1000);
    do_read(3'd3, 2'd1, 32'h0000_0824, 1'b0, "rd fsr1", 1'b0, 2'd0, 32'h0, 32'h0);
    do_read(3'd3, 2'd1, 32'h0000_0000, 1'b0, "rd fsr1 clr", 1'b0, 2'd0, 32'h0, 32'h0);
    do_read(3'd4, 2'd1, 32'h4000_1000, 1'b0, "rd far1", 1'b0, 2'd0, 32'h0, 32'h0);
    do_read(3'd4, 2'd1, 32'h4000_1000, 1'b0, "rd far1 again", 1'b0, 2'd0, 32'h0, 32'h0);

    // 3: same-thread fault during read suppresses the clear
    fault(2'd1, 32'h0000_0824, 32'h4000_1000);
    do_read(3'd3, 2'd1, 32'h0000_0824, 1'b0, "rd fsr1 sup", 1'b1, 2'd1, 32'h0000_0C2C, 32'h4000_2000);
    do_read(3'd3, 2'd1, 32'h0000_0C2C, 1'b0, "rd fsr1 new", 1'b0, 2'd0, 32'h0, 32'h0);
    do_read(3'd3, 2'd1, 32'h0000_0000, 1'b0, "rd fsr1 zero", 1'b0, 2'd0, 32'h0, 32'h0);

    // Other-thread fault in RD_WAIT defers the clear instead of losing it
    fault(2'd1, 32'h0000_0055, 32'h0);
    do_read(3'd3, 2'd1, 32'h0000_0055, 1'b0, "rd fsr1 dly", 1'b1, 2'd2, 32'h0000_0066, 32'h0000_0077);
    do_read(3'd3, 2'd1, 32'h0000_0000, 1'b0, "rd fsr1 dly clr", 1'b0, 2'd0, 32'h0, 32'h0);
    do_read(3'd3, 2'd2, 32'h0000_0066, 1'b0, "rd fsr2", 1'b0, 2'd0, 32'h0, 32'h0);

    // 4: FAR write blocked by fault, lands next cycle
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_sel = 3'd4; req_tid = 2'd0; req_wdata = 32'hDEAD_0000;
    flt_valid = 1'b1; flt_tid = 2'd3; flt_fsr = 32'h0000_0033; flt_far = 32'h0000_0FA3;
    #1;
    check("far conflict ready", 32'(req_ready), 32'd0);
    check("far conflict we", 32'(reg_we), 32'b11000);
    check("far conflict wtid", 32'(reg_wtid), 32'd3);
    @(posedge clk);
    #1;
    flt_valid = 1'b0;
    @(negedge clk);
    #1;
    check("far retry ready", 32'(req_ready), 32'd1);
    check("far retry we", 32'(reg_we), 32'b10000);
    check("far retry wtid", 32'(reg_wtid), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0;
    do_read(3'd4, 2'd0, 32'hDEAD_0000, 1'b0, "rd far0", 1'b0, 2'd0, 32'h0, 32'h0);
    do_read(3'd4, 2'd3, 32'h0000_0FA3, 1'b0, "rd far3", 1'b0, 2'd0, 32'h0, 32'h0);
    do_read(3'd3, 2'd3, 32'h0000_0033, 1'b0, "rd fsr3", 1'b0, 2'd0, 32'h0, 32'h0);

    // Parallel ctrl write with same-thread fault; ctxptr write with other-thread fault blocks
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_sel = 3'd0; req_tid = 2'd1; req_wdata = 32'h1234_5678;
    flt_valid = 1'b1; flt_tid = 2'd1; flt_fsr = 32'h1; flt_far = 32'h2;
    #1;
    check("par same ready", 32'(req_ready), 32'd1);
    check("par same we", 32'(reg_we), 32'b11001);
    @(posedge clk);
    #1;
    req_sel = 3'd1; req_tid = 2'd0; flt_tid = 2'd2;
    @(negedge clk);
    #1;
    check("par diff ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    flt_valid = 1'b0;
    req_valid = 1'b0; req_we = 1'b0;

    // 5: parity error and illegal select
    reg_luterr = 5'b00001;
    do_read(3'd0, 2'd1, 32'h1234_5678, 1'b1, "rd ctrl luterr", 1'b0, 2'd0, 32'h0, 32'h0);
    reg_luterr = '0;
    cnt0 = we_cnt;
    do_read(3'd6, 2'd0, 32'h0000_0000, 1'b1, "rd sel6", 1'b0, 2'd0, 32'h0, 32'h0);
    send(1'b1, 3'd6, 2'd0, 32'hFFFF_FFFF, "wr sel6");
    @(negedge clk);
    check("illegal no we", 32'(we_cnt - cnt0), 32'd0);

    // 6: stalled response, then reset in RSP
    send(1'b0, 3'd2, 2'd2, 32'h0, "rd stall");
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("stall valid", 32'(rsp_valid), 32'd1);
      check("stall data", rsp_data, 32'h0000_00A5);
      check("stall ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst rsp valid", 32'(rsp_valid), 32'd0);
    check("rst rsp data", rsp_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post rst idle", 32'(req_ready), 32'd1);
    check("post rst valid", 32'(rsp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
